// File: rtl/mips_mem_arbiter.sv
// Shared-bus memory front-end for the pipelined MIPS core.
// Serialises data and fetch accesses onto one handshaked bus and stalls the pipe.
module mips_mem_arbiter #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     pcF,
    input  logic              ireqF,
    output logic [DW-1:0]     instrF,
    input  logic              dreqM,
    input  logic              dwriteM,
    input  logic [AW-1:0]     daddrM,
    input  logic [1:0]        dsizeM,
    input  logic [DW-1:0]     dwdataM,
    output logic [DW-1:0]     drdataM,
    output logic              dmisalignM,
    output logic              stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [AW-1:0]     bus_addr,
    output logic [DW/8-1:0]   bus_be,
    output logic [DW-1:0]     bus_wdata,
    input  logic              bus_ack,
    input  logic [DW-1:0]     bus_rdata
);

    localparam int BEW = DW / 8;
    localparam int OW  = $clog2(BEW);
    localparam logic [AW-1:0] AMASK = ~(AW'(BEW - 1));

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DBUS = 2'd1;
    localparam logic [1:0] S_IBUS = 2'd2;

    logic [1:0]     r_state;
    logic           r_idone;
    logic           r_ddone;
    logic           r_mis;
    logic [AW-1:0]  r_addr;
    logic           r_we;
    logic [BEW-1:0] r_be;
    logic [DW-1:0]  r_wdata;
    logic [DW-1:0]  r_instr;
    logic [DW-1:0]  r_rdata;

    logic           w_stall;
    logic           w_mis;
    logic           w_dgo;
    logic           w_igo;
    logic           w_dbad;
    logic [BEW-1:0] w_mask;
    logic [BEW-1:0] w_be;
    logic [DW-1:0]  w_wdata;

    assign w_stall = (ireqF & ~r_idone) | (dreqM & ~r_ddone);

    // dword never fits a 32-bit bus, so it is always rejected there
    always_comb begin
        w_mis = 1'b0;
        case (dsizeM)
            2'b00:   w_mis = 1'b0;
            2'b01:   w_mis = daddrM[0];
            2'b10:   w_mis = |daddrM[1:0];
            default: w_mis = (DW == 32) | (|daddrM[2:0]);
        endcase
    end

    always_comb begin
        w_mask = '0;
        case (dsizeM)
            2'b00:   w_mask = BEW'(1);
            2'b01:   w_mask = BEW'(3);
            2'b10:   w_mask = BEW'(15);
            default: w_mask = {BEW{1'b1}};
        endcase
    end

    assign w_be = w_mask << daddrM[OW-1:0];

    always_comb begin
        w_wdata = '0;
        for (int i = 0; i < BEW; i++) begin
            case (dsizeM)
                2'b00:   w_wdata[8*i +: 8] = dwdataM[7:0];
                2'b01:   w_wdata[8*i +: 8] = dwdataM[8*(i%2) +: 8];
                2'b10:   w_wdata[8*i +: 8] = dwdataM[8*(i%4) +: 8];
                default: w_wdata[8*i +: 8] = dwdataM[8*(i%8) +: 8];
            endcase
        end
    end

    assign w_dbad = dreqM & ~r_ddone & w_mis;
    assign w_dgo  = dreqM & ~r_ddone & ~w_mis;
    assign w_igo  = ireqF & ~r_idone;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_idone <= 1'b0;
            r_ddone <= 1'b0;
            r_mis   <= 1'b0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
            r_instr <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_dgo) begin
                        r_state <= S_DBUS;
                        r_addr  <= daddrM & AMASK;
                        r_we    <= dwriteM;
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                    end else if (w_igo) begin
                        r_state <= S_IBUS;
                        r_addr  <= pcF & AMASK;
                        r_we    <= 1'b0;
                        r_be    <= {BEW{1'b1}};
                    end
                    if (w_dbad) begin
                        r_ddone <= 1'b1;
                        r_mis   <= 1'b1;
                    end
                end
                S_DBUS: begin
                    if (bus_ack) begin
                        r_ddone <= 1'b1;
                        r_rdata <= bus_rdata;
                        r_state <= S_IDLE;
                    end
                end
                S_IBUS: begin
                    if (bus_ack) begin
                        r_idone <= 1'b1;
                        r_instr <= bus_rdata;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // pipeline advances on this edge: start a fresh request window
            if (!w_stall) begin
                r_idone <= 1'b0;
                r_ddone <= 1'b0;
                r_mis   <= 1'b0;
            end
        end
    end

    assign stall      = w_stall;
    assign bus_req    = (r_state != S_IDLE);
    assign bus_we     = r_we;
    assign bus_addr   = r_addr;
    assign bus_be     = r_be;
    assign bus_wdata  = r_wdata;
    assign instrF     = r_instr;
    assign drdataM    = r_rdata;
    assign dmisalignM = r_mis;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: vector table on a 32-bit
// instance plus hand sequences for reset abort and a 64-bit instance.
module tb_mips_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [31:0] pcF, daddrM, dwdataM, instrF, drdataM;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        ireqF, dreqM, dwriteM, dmisalignM, stall;
    logic        bus_req, bus_we, bus_ack;
    logic [1:0]  dsizeM;
    logic [3:0]  bus_be;

    logic [31:0] pc64, daddr64;
    logic [63:0] dwd64, instr64, drd64, bwd64, brd64;
    logic [31:0] baddr64;
    logic        ireq64, dreq64, dwr64, dmis64, stall64;
    logic        breq64, bwe64, back64;
    logic [1:0]  dsz64;
    logic [7:0]  bbe64;

    int lat;
    int wcnt;
    int n_cmp = 0;
    int n_bad = 0;

    mips_mem_arbiter #(.DW(32), .AW(32)) u32 (
        .clk(clk), .rst(rst), .pcF(pcF), .ireqF(ireqF), .instrF(instrF),
        .dreqM(dreqM), .dwriteM(dwriteM), .daddrM(daddrM), .dsizeM(dsizeM),
        .dwdataM(dwdataM), .drdataM(drdataM), .dmisalignM(dmisalignM),
        .stall(stall), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    mips_mem_arbiter #(.DW(64), .AW(32)) u64 (
        .clk(clk), .rst(rst), .pcF(pc64), .ireqF(ireq64), .instrF(instr64),
        .dreqM(dreq64), .dwriteM(dwr64), .daddrM(daddr64), .dsizeM(dsz64),
        .dwdataM(dwd64), .drdataM(drd64), .dmisalignM(dmis64),
        .stall(stall64), .bus_req(breq64), .bus_we(bwe64),
        .bus_addr(baddr64), .bus_be(bbe64), .bus_wdata(bwd64),
        .bus_ack(back64), .bus_rdata(brd64)
    );

    // slave model: ack after lat wait cycles, data derived from address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wcnt <= 0;
        else if (bus_req && !bus_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end
    assign bus_ack   = bus_req && (wcnt >= lat);
    assign bus_rdata = bus_addr ^ 32'hDEAD_0000;
    assign back64    = breq64;
    assign brd64     = {~baddr64, baddr64};

    typedef struct {
        logic        ireq;
        logic [31:0] pc;
        logic        dreq;
        logic        dwr;
        logic [31:0] da;
        logic [1:0]  sz;
        logic [31:0] wd;
        int          xs;
        int          xn;
        logic [31:0] xa;
        logic [3:0]  xbe;
        logic        xwe;
        logic        cw;
        logic [31:0] xwd;
        logic [31:0] xa2;
        logic        xmis;
    } vec_t;

    function automatic vec_t mk(
        logic ireq, logic [31:0] pc, logic dreq, logic dwr,
        logic [31:0] da, logic [1:0] sz, logic [31:0] wd,
        int xs, int xn, logic [31:0] xa, logic [3:0] xbe, logic xwe,
        logic cw, logic [31:0] xwd, logic [31:0] xa2, logic xmis);
        vec_t v;
        v.ireq = ireq; v.pc = pc; v.dreq = dreq; v.dwr = dwr;
        v.da = da; v.sz = sz; v.wd = wd; v.xs = xs; v.xn = xn;
        v.xa = xa; v.xbe = xbe; v.xwe = xwe; v.cw = cw;
        v.xwd = xwd; v.xa2 = xa2; v.xmis = xmis;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int k, input vec_t v);
        logic [31:0] a0, a1, wd0;
        logic [3:0]  be0;
        logic        we0;
        int          n, cyc;
        @(negedge clk);
        ireqF = v.ireq; pcF = v.pc; dreqM = v.dreq; dwriteM = v.dwr;
        daddrM = v.da; dsizeM = v.sz; dwdataM = v.wd;
        #1;
        n = 0; cyc = 0;
        a0 = 'x; a1 = 'x; wd0 = 'x; be0 = 'x; we0 = 1'bx;
        while (stall && cyc < 40) begin
            if (bus_req && bus_ack) begin
                if (n == 0) begin
                    a0 = bus_addr; be0 = bus_be;
                    we0 = bus_we; wd0 = bus_wdata;
                end else if (n == 1) begin
                    a1 = bus_addr;
                end
                n++;
            end
            cyc++;
            @(negedge clk); #1;
        end
        chk($sformatf("v%0d_stall_cycles", k), 64'(cyc), 64'(v.xs));
        chk($sformatf("v%0d_transfers", k), 64'(n), 64'(v.xn));
        chk($sformatf("v%0d_misalign", k), 64'(dmisalignM), 64'(v.xmis));
        if (v.xn > 0) begin
            chk($sformatf("v%0d_addr", k), 64'(a0), 64'(v.xa));
            chk($sformatf("v%0d_be", k), 64'(be0), 64'(v.xbe));
            chk($sformatf("v%0d_we", k), 64'(we0), 64'(v.xwe));
        end
        if (v.cw)
            chk($sformatf("v%0d_wdata", k), 64'(wd0), 64'(v.xwd));
        if (v.xn > 1)
            chk($sformatf("v%0d_addr2", k), 64'(a1), 64'(v.xa2));
        if (v.ireq)
            chk($sformatf("v%0d_instrF", k), 64'(instrF),
                64'((v.pc & 32'hFFFF_FFFC) ^ 32'hDEAD_0000));
        if (v.dreq && !v.dwr && !v.xmis)
            chk($sformatf("v%0d_drdataM", k), 64'(drdataM),
                64'((v.da & 32'hFFFF_FFFC) ^ 32'hDEAD_0000));
        ireqF = 1'b0;
        dreqM = 1'b0;
    endtask

    vec_t vt[10];

    initial begin
        vt[0] = mk(1, 32'h40, 0, 0, 32'h0, 2'd0, 32'h0,
                   2, 1, 32'h40, 4'hF, 0, 0, 32'h0, 32'h0, 0);
        vt[1] = mk(1, 32'h100, 1, 0, 32'h200, 2'd2, 32'h0,
                   4, 2, 32'h200, 4'hF, 0, 0, 32'h0, 32'h100, 0);
        vt[2] = mk(0, 32'h0, 1, 1, 32'h203, 2'd0, 32'hAB,
                   2, 1, 32'h200, 4'h8, 1, 1, 32'hABABABAB, 32'h0, 0);
        vt[3] = mk(0, 32'h0, 1, 0, 32'h201, 2'd1, 32'h0,
                   1, 0, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 1);
        vt[4] = mk(0, 32'h0, 1, 1, 32'h202, 2'd1, 32'h1234,
                   2, 1, 32'h200, 4'hC, 1, 1, 32'h12341234, 32'h0, 0);
        vt[5] = mk(0, 32'h0, 1, 1, 32'h204, 2'd2, 32'hCAFEBABE,
                   2, 1, 32'h204, 4'hF, 1, 1, 32'hCAFEBABE, 32'h0, 0);
        vt[6] = mk(0, 32'h0, 1, 0, 32'h105, 2'd0, 32'h0,
                   2, 1, 32'h104, 4'h2, 0, 0, 32'h0, 32'h0, 0);
        vt[7] = mk(0, 32'h0, 1, 0, 32'h208, 2'd3, 32'h0,
                   1, 0, 32'h0, 4'h0, 0, 0, 32'h0, 32'h0, 1);
        vt[8] = mk(1, 32'h300, 1, 0, 32'h302, 2'd2, 32'h0,
                   2, 1, 32'h300, 4'hF, 0, 0, 32'h0, 32'h0, 1);
        vt[9] = mk(1, 32'h80, 1, 1, 32'h401, 2'd0, 32'h5A,
                   4, 2, 32'h400, 4'h2, 1, 1, 32'h5A5A5A5A, 32'h80, 0);

        lat = 0;
        rst = 1'b0;
        ireqF = 0; pcF = 0; dreqM = 0; dwriteM = 0;
        daddrM = 0; dsizeM = 0; dwdataM = 0;
        ireq64 = 0; pc64 = 0; dreq64 = 0; dwr64 = 0;
        daddr64 = 0; dsz64 = 0; dwd64 = 0;
        #12;
        chk("rst_bus_req", 64'(bus_req), 64'd0);
        chk("rst_bus_be", 64'(bus_be), 64'd0);
        chk("rst_bus_addr", 64'(bus_addr), 64'd0);
        chk("rst_instrF", 64'(instrF), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < 10; k++) run_vec(k, vt[k]);

        // slow slave, then a non-fetch access: instrF must hold
        lat = 2;
        run_vec(10, mk(1, 32'h700, 0, 0, 32'h0, 2'd0, 32'h0,
                       4, 1, 32'h700, 4'hF, 0, 0, 32'h0, 32'h0, 0));
        lat = 0;
        run_vec(11, mk(0, 32'h0, 1, 1, 32'h20, 2'd2, 32'h11223344,
                       2, 1, 32'h20, 4'hF, 1, 1, 32'h11223344, 32'h0, 0));
        chk("instrF_hold", 64'(instrF), 64'h0000_0000_DEAD_0700);

        // reset while a transfer is waiting for ack
        lat = 6;
        @(negedge clk);
        ireqF = 1'b1; pcF = 32'h500;
        @(negedge clk); @(negedge clk); #1;
        chk("abort_req_before", 64'(bus_req), 64'd1);
        rst = 1'b0;
        #1;
        chk("abort_req", 64'(bus_req), 64'd0);
        chk("abort_addr", 64'(bus_addr), 64'd0);
        chk("abort_be", 64'(bus_be), 64'd0);
        chk("abort_we", 64'(bus_we), 64'd0);
        chk("abort_wdata", 64'(bus_wdata), 64'd0);
        chk("abort_instrF", 64'(instrF), 64'd0);
        chk("abort_drdataM", 64'(drdataM), 64'd0);
        chk("abort_mis", 64'(dmisalignM), 64'd0);
        chk("abort_stall", 64'(stall), 64'd1);
        ireqF = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        lat = 0;
        run_vec(12, mk(1, 32'h600, 0, 0, 32'h0, 2'd0, 32'h0,
                       2, 1, 32'h600, 4'hF, 0, 0, 32'h0, 32'h0, 0));

        // 64-bit bus: dword store, misaligned dword, upper word, fetch
        @(negedge clk);
        dreq64 = 1; dwr64 = 1; daddr64 = 32'h18; dsz64 = 2'd3;
        dwd64 = 64'h1122_3344_5566_7788;
        @(negedge clk); #1;
        chk("d64_req", 64'(breq64), 64'd1);
        chk("d64_addr", 64'(baddr64), 64'h18);
        chk("d64_be", 64'(bbe64), 64'hFF);
        chk("d64_we", 64'(bwe64), 64'd1);
        chk("d64_wdata", bwd64, 64'h1122_3344_5566_7788);
        @(negedge clk); #1;
        chk("d64_stall_done", 64'(stall64), 64'd0);
        dreq64 = 0;

        @(negedge clk);
        dreq64 = 1; dwr64 = 0; daddr64 = 32'h1C; dsz64 = 2'd3;
        #1;
        chk("mis64_stall", 64'(stall64), 64'd1);
        @(negedge clk); #1;
        chk("mis64_stall_done", 64'(stall64), 64'd0);
        chk("mis64_flag", 64'(dmis64), 64'd1);
        chk("mis64_noreq", 64'(breq64), 64'd0);
        dreq64 = 0;

        @(negedge clk);
        dreq64 = 1; dwr64 = 1; daddr64 = 32'h1C; dsz64 = 2'd2;
        dwd64 = 64'h0000_0000_CAFE_BABE;
        @(negedge clk); #1;
        chk("w64_addr", 64'(baddr64), 64'h18);
        chk("w64_be", 64'(bbe64), 64'hF0);
        chk("w64_wdata", bwd64, 64'hCAFE_BABE_CAFE_BABE);
        @(negedge clk); #1;
        dreq64 = 0;

        @(negedge clk);
        ireq64 = 1; pc64 = 32'h44;
        @(negedge clk); #1;
        chk("f64_addr", 64'(baddr64), 64'h40);
        chk("f64_be", 64'(bbe64), 64'hFF);
        chk("f64_we", 64'(bwe64), 64'd0);
        @(negedge clk); #1;
        chk("f64_stall_done", 64'(stall64), 64'd0);
        chk("f64_instr", instr64, 64'hFFFF_FFBF_0000_0040);
        ireq64 = 0;

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
